// File: rtl/axis_m_pktgen.sv
// AXI-Stream master packet generator: emits one packet of pkt_len incrementing beats
// starting at seed per accepted start pulse, honouring tready back-pressure.
module axis_m_pktgen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    logic              r_state;
    logic [LEN_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_done;

    logic              w_state_d;
    logic [LEN_W-1:0]  w_remaining_d;
    logic [DATA_W-1:0] w_tdata_d;
    logic              w_tvalid_d;
    logic              w_tlast_d;
    logic              w_done_d;

    always_comb begin
        w_state_d     = r_state;
        w_remaining_d = r_remaining;
        w_tdata_d     = r_tdata;
        w_tvalid_d    = r_tvalid;
        w_tlast_d     = r_tlast;
        w_done_d      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A zero-length request is dropped silently: no beats, no done.
                if (start && (pkt_len != '0)) begin
                    w_state_d     = ST_SEND;
                    w_tvalid_d    = 1'b1;
                    w_tdata_d     = seed;
                    w_remaining_d = pkt_len;
                    w_tlast_d     = (pkt_len == LEN_W'(1));
                end
            end
            ST_SEND: begin
                if (r_tvalid && m_axis_tready) begin
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_d     = ST_IDLE;
                        w_tvalid_d    = 1'b0;
                        w_tlast_d     = 1'b0;
                        w_remaining_d = '0;
                        w_done_d      = 1'b1;
                    end else begin
                        w_tdata_d     = r_tdata + DATA_W'(1);
                        w_remaining_d = r_remaining - LEN_W'(1);
                        w_tlast_d     = (r_remaining == LEN_W'(2));
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_remaining <= w_remaining_d;
            r_tdata     <= w_tdata_d;
            r_tvalid    <= w_tvalid_d;
            r_tlast     <= w_tlast_d;
            r_done      <= w_done_d;
        end
    end

    assign busy          = (r_state == ST_SEND);
    assign done          = r_done;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_axis_m_pktgen.sv
// Scoreboard bench for axis_m_pktgen: stimulus pushes expected beats, a negedge monitor
// pops and compares on every handshake and checks done/busy/stall-stability rules.
module tb_axis_m_pktgen;

    logic       clk;
    logic       aresetn;
    logic       start;
    logic [7:0] pkt_len;
    logic [7:0] seed;
    logic       busy;
    logic       done;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;

    logic [8:0] exp_q[$];   // {tlast, tdata}
    int         n_vec;
    int         n_err;

    logic       prev_stall;
    logic       prev_last_hs;
    logic [7:0] prev_data;
    logic       prev_last;

    axis_m_pktgen #(
        .DATA_W(8),
        .LEN_W (8)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_aresetn(aresetn),
        .start         (start),
        .pkt_len       (pkt_len),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!aresetn) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            check("done_timing", {31'b0, done}, {31'b0, prev_last_hs});
            check("busy_eq_tvalid", {31'b0, busy}, {31'b0, tvalid});
            if (prev_stall) begin
                check("stall_tvalid", {31'b0, tvalid}, 32'd1);
                check("stall_tdata", {24'b0, tdata}, {24'b0, prev_data});
                check("stall_tlast", {31'b0, tlast}, {31'b0, prev_last});
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {23'b0, tlast, tdata}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {23'b0, tlast, tdata}, {23'b0, e});
                end
            end
            prev_stall   = tvalid && !tready;
            prev_data    = tdata;
            prev_last    = tlast;
            prev_last_hs = tvalid && tready && tlast;
        end
    end

    task automatic push_pkt(input int len, input logic [7:0] s);
        logic [7:0] d;
        d = s;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), d});
            d = d + 8'd1;
        end
    endtask

    // Pulses start for one cycle; inputs change just after the rising edge.
    task automatic start_pkt(input logic [7:0] len, input logic [7:0] s, input bit expect_pkt);
        start   = 1'b1;
        pkt_len = len;
        seed    = s;
        if (expect_pkt) push_pkt(int'(len), s);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || tvalid) && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(name, {31'b0, (cyc >= 300)}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        n_vec = 0; n_err = 0;
        prev_stall = 1'b0; prev_last_hs = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
        aresetn = 1'b0; start = 1'b0; pkt_len = 8'd0; seed = 8'd0; tready = 1'b1;
        #3;
        check("rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("rst_tlast", {31'b0, tlast}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_tdata", {24'b0, tdata}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;

        // Wrap-around packet, full throughput.
        start_pkt(8'd4, 8'hFE, 1'b1);
        check("first_beat_latency", {23'b0, tvalid, tdata}, {23'b0, 1'b1, 8'hFE});
        wait_drain("drain_wrap");

        // Back-pressure: tready 1,0,0,1,0,1 once the first beat is valid.
        start_pkt(8'd3, 8'h10, 1'b1);
        begin
            logic [5:0] pat;
            pat = 6'b101001;   // bit 0 applied first
            for (int i = 0; i < 6; i++) begin
                tready = pat[i];
                @(posedge clk); #1;
            end
        end
        tready = 1'b1;
        check("stall_all_accepted", exp_q.size(), 32'd0);
        wait_drain("drain_stall");

        // Single-beat packet.
        start_pkt(8'd1, 8'hA5, 1'b1);
        check("single_tlast", {30'b0, tvalid, tlast}, 32'd3);
        wait_drain("drain_single");

        // Zero-length request is ignored.
        start_pkt(8'd0, 8'h55, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("len0_idle", {29'b0, tvalid, busy, done}, 32'd0);
            @(posedge clk); #1;
        end

        // Start during SEND is ignored.
        start_pkt(8'd5, 8'h30, 1'b1);
        start_pkt(8'd2, 8'h99, 1'b0);
        wait_drain("drain_busy_start");

        // Start in the done cycle: one idle cycle between packets.
        start_pkt(8'd3, 8'h70, 1'b1);
        cyc = 0;
        while (!done && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
        check("gap_tvalid", {31'b0, tvalid}, 32'd0);
        start_pkt(8'd2, 8'h20, 1'b1);
        check("b2b_first", {23'b0, tvalid, tdata}, {23'b0, 1'b1, 8'h20});
        wait_drain("drain_b2b");

        // Reset after beat 2 of 6.
        start_pkt(8'd6, 8'h40, 1'b1);
        cyc = 0;
        while (exp_q.size() > 4 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reset_two_beats", exp_q.size(), 32'd4);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_tvalid", {31'b0, tvalid}, 32'd0);
        check("async_tlast", {31'b0, tlast}, 32'd0);
        check("async_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        check("post_reset_done", {31'b0, done}, 32'd0);
        start_pkt(8'd2, 8'h60, 1'b1);
        wait_drain("drain_post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
